// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized line, half-bit start qualification,
// mid-bit sampling, single-entry output register with overrun and framing flags.
module uart_rx #(
    parameter int SYS_CLOCK = 1000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_input,
    input  logic       read_ack,
    output logic [7:0] data_output,
    output logic       data_valid,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun
);

    localparam int DIVISION = SYS_CLOCK / BAUD_RATE;
    localparam int HALF = DIVISION / 2;
    localparam logic [15:0] DIV_LAST = 16'(DIVISION - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic        sync1;
    logic        line;
    logic        prev_line;
    logic [15:0] counter;
    logic [2:0]  index;
    logic [7:0]  shift;

    // Synchronizer and edge history reset high so a released reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            prev_line <= 1'b1;
        end else begin
            sync1     <= rx_input;
            line      <= sync1;
            prev_line <= line;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= 16'd0;
            index       <= 3'd0;
            shift       <= 8'h00;
            data_output <= 8'h00;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (read_ack && data_valid) begin
                data_valid <= 1'b0;
            end
            if (read_ack) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (prev_line && !line) begin
                        state   <= START;
                        counter <= 16'd0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (counter == HALF_LAST) begin
                        counter <= 16'd0;
                        if (!line) begin
                            state <= DATA;
                            index <= 3'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                DATA: begin
                    if (counter == DIV_LAST) begin
                        counter      <= 16'd0;
                        shift[index] <= line;
                        if (index == 3'd7) begin
                            state <= STOP;
                        end else begin
                            index <= index + 3'd1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                STOP: begin
                    if (counter == DIV_LAST) begin
                        counter <= 16'd0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        if (line) begin
                            // A new byte always wins over a same-cycle acknowledge.
                            data_output <= shift;
                            data_valid  <= 1'b1;
                            if (data_valid && !read_ack) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame driver, expected-byte queue with a decoupled monitor,
// directed corner cases followed by randomized frames.
module tb_uart_rx;

    localparam int BIT = 104;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_input = 1'b1;
    logic       mon_ack = 1'b0;
    logic       drv_ack = 1'b0;
    logic       read_ack;
    logic [7:0] data_output;
    logic       data_valid;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    assign read_ack = mon_ack | drv_ack;

    uart_rx #(.SYS_CLOCK(1000000), .BAUD_RATE(9600)) dut (
        .clk(clk),
        .reset(reset),
        .rx_input(rx_input),
        .read_ack(read_ack),
        .data_output(data_output),
        .data_valid(data_valid),
        .busy(busy),
        .frame_error(frame_error),
        .overrun(overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: {expected overrun, expected byte}
    int          total = 0;
    int          bad = 0;
    logic [8:0]  exp_q[$];
    int          exp_fe = 0;
    int          seen_fe = 0;
    bit          auto_ack = 1'b1;
    int unsigned start_cyc = 0;
    int unsigned load_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d..%0d", name, got, lo, hi);
        end
    endtask

    // monitor: pops on every new byte presented, acknowledges when auto_ack is on
    logic       p_valid = 1'b0;
    logic       p_fe = 1'b0;
    logic [7:0] p_out = 8'h00;
    logic [8:0] mon_e;

    always @(negedge clk) begin
        if (reset) begin
            mon_ack = 1'b0;
        end else begin
            if ((data_valid && !p_valid) || (data_output != p_out)) begin
                load_cyc = cyc;
                if (!data_valid) begin
                    check("spurious_output", 32'(data_output), 32'(p_out));
                end else if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got=%0h want=none", data_output);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_byte", 32'(data_output), 32'(mon_e[7:0]));
                    check("rx_overrun", 32'(overrun), 32'(mon_e[8]));
                end
            end
            if (frame_error) begin
                seen_fe++;
                check("fe_single_cycle", 32'(p_fe), 32'd0);
            end
            mon_ack = auto_ack && data_valid && !mon_ack;
        end
        p_valid = data_valid;
        p_out   = data_output;
        p_fe    = frame_error;
    end

    // driver: one 8N1 frame; ack_k pulses read_ack at that bit-cycle, rst_k aborts with reset
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ovr,
                              input bit glitch, input int ack_k, input int rst_k);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        if (rst_k < 0) begin
            if (stop_ok) exp_q.push_back({ovr, b});
            else exp_fe++;
        end
        for (int k = 0; k < 10 * BIT; k++) begin
            @(negedge clk);
            if (k == 0) start_cyc = cyc;
            if (k == rst_k) begin
                reset = 1'b1;
                rx_input = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b0;
                return;
            end
            rx_input = frame[k / BIT] ^ (glitch && (k % BIT) >= 20 && (k % BIT) <= 24);
            drv_ack = (k == ack_k);
        end
        @(negedge clk);
        rx_input = 1'b1;
        drv_ack = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        bit rok;
        bit rg;
        int unsigned t0;

        repeat (4) @(negedge clk);
        check("rst_data_output", 32'(data_output), 32'h00);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // nominal byte and its latency from the start edge
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, -1);
        check_range("latency", int'(load_cyc - start_cyc), 990, 992);
        repeat (30) @(negedge clk);

        // short low pulse is rejected at the half-bit check
        rx_input = 1'b0;
        t0 = cyc;
        repeat (10) @(negedge clk);
        check("glitch_busy_high", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        rx_input = 1'b1;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check_range("glitch_busy_len", int'(cyc - t0), 54, 56);
        repeat (30) @(negedge clk);

        // bad stop bit
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);
        check("fe_no_valid", 32'(data_valid), 32'd0);
        check("fe_hold_output", 32'(data_output), 32'hA5);
        check("fe_count_mid", 32'(seen_fe), 32'(exp_fe));
        repeat (30) @(negedge clk);

        // overrun without acknowledge, then clear
        auto_ack = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1, -1);
        repeat (20) @(negedge clk);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0, -1, -1);
        check("ovr_data", 32'(data_output), 32'h22);
        check("ovr_valid", 32'(data_valid), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        @(negedge clk);
        drv_ack = 1'b1;
        @(negedge clk);
        drv_ack = 1'b0;
        check("ack_clears_valid", 32'(data_valid), 32'd0);
        check("ack_clears_overrun", 32'(overrun), 32'd0);
        repeat (20) @(negedge clk);

        // acknowledge lands on the same edge as the next good stop bit
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1, -1);
        repeat (20) @(negedge clk);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 990, -1);
        check("same_cycle_valid", 32'(data_valid), 32'd1);
        check("same_cycle_data", 32'(data_output), 32'h55);
        check("same_cycle_overrun", 32'(overrun), 32'd0);
        auto_ack = 1'b1;
        repeat (20) @(negedge clk);

        // reset in the middle of a frame
        send_frame(8'h99, 1'b1, 1'b0, 1'b0, -1, 5 * BIT + 20);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(data_valid), 32'd0);
        check("midrst_output", 32'(data_output), 32'h00);
        repeat (50) @(negedge clk);
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0, -1, -1);
        check("post_rst_data", 32'(data_output), 32'hF0);
        repeat (30) @(negedge clk);

        // randomized frames with occasional bad stop bits and inter-sample glitches
        for (int n = 0; n < 12; n++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 99) < 80);
            rg  = 1'($urandom_range(0, 1));
            send_frame(rb, rok, 1'b0, rg, -1, -1);
            repeat ($urandom_range(5, 60)) @(negedge clk);
        end

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame_error_total", 32'(seen_fe), 32'(exp_fe));
        check("final_overrun", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
